line_clear: RTL and testbench

LINE_CLEAR -- requirements
Module: line_clear

---
 rtl/line_clear.sv | 148 ++++++++++++++
 tb/tb_line_clear.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear.sv
// Clears full rows from a block-stacking game board held in an external synchronous RAM.
// Scans from the bottom row up. When it finds a full row, it shifts every row above it down by one.
module line_clear #(
  parameter int unsigned BOARD_W = 10,
  parameter int unsigned BOARD_H = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  input  logic [5:0] ram_q,
  output logic [7:0] ram_addr,
  output logic       ram_wren,
  output logic [5:0] ram_data,
  output logic       busy,
  output logic       complete,
  output logic [2:0] lines_cleared
);

  typedef enum logic [2:0] {
    StIdle,
    StScanRd,
    StScanChk,
    StShiftRd,
    StShiftWr,
    StClearTop,
    StDone
  } state_e;

  localparam logic [4:0] LastRow = 5'(BOARD_H - 1);
  localparam logic [3:0] LastCol = 4'(BOARD_W - 1);

  state_e     state_q, state_d;
  logic [4:0] row_q, row_d;
  logic [4:0] srow_q, srow_d;
  logic [3:0] col_q, col_d;
  logic [2:0] lines_q, lines_d;
  logic [7:0] addr_d;

  function automatic logic [7:0] cell_addr(input logic [4:0] r, input logic [3:0] c);
    int unsigned a;
    a = 32'(r) * BOARD_W + 32'(c);
    return a[7:0];
  endfunction

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    srow_d  = srow_q;
    col_d   = col_q;
    lines_d = lines_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StScanRd;
          row_d   = LastRow;
          col_d   = '0;
          lines_d = '0;
        end
      end
      StScanRd: state_d = StScanChk;
      StScanChk: begin
        if (ram_q == '0) begin
          if (row_q == '0) begin
            state_d = StDone;
          end else begin
            row_d   = row_q - 5'd1;
            col_d   = '0;
            state_d = StScanRd;
          end
        end else if (col_q < LastCol) begin
          col_d   = col_q + 4'd1;
          state_d = StScanRd;
        end else begin
          if (lines_q != 3'd7) lines_d = lines_q + 3'd1;
          srow_d  = row_q;
          col_d   = '0;
          state_d = (row_q == '0) ? StClearTop : StShiftRd;
        end
      end
      StShiftRd: state_d = StShiftWr;
      StShiftWr: begin
        if (col_q < LastCol) begin
          col_d   = col_q + 4'd1;
          state_d = StShiftRd;
        end else if (srow_q > 5'd1) begin
          srow_d  = srow_q - 5'd1;
          col_d   = '0;
          state_d = StShiftRd;
        end else begin
          col_d   = '0;
          state_d = StClearTop;
        end
      end
      StClearTop: begin
        if (col_q == LastCol) begin
          // Row is left as is so the row just pulled down gets rescanned.
          col_d   = '0;
          state_d = StScanRd;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state_q.
  always_comb begin
    addr_d = '0;
    unique case (state_d)
      StScanRd, StScanChk: addr_d = cell_addr(row_d, col_d);
      StShiftRd:           addr_d = cell_addr(srow_d - 5'd1, col_d);
      StShiftWr:           addr_d = cell_addr(srow_d, col_d);
      StClearTop:          addr_d = cell_addr(5'd0, col_d);
      default:             addr_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      row_q    <= '0;
      srow_q   <= '0;
      col_q    <= '0;
      lines_q  <= '0;
      ram_addr <= '0;
      ram_wren <= 1'b0;
      busy     <= 1'b0;
      complete <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      srow_q   <= srow_d;
      col_q    <= col_d;
      lines_q  <= lines_d;
      ram_addr <= addr_d;
      ram_wren <= (state_d == StShiftWr) || (state_d == StClearTop);
      busy     <= (state_d != StIdle);
      complete <= (state_d == StDone);
    end
  end

  // Read data for the row above arrives in the write cycle, so it passes straight through.
  assign ram_data      = (state_q == StShiftWr) ? ram_q : 6'd0;
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: directed board scenarios plus random boards.
// Results are compared against a row-removal reference model.
module tb_line_clear;
  localparam int unsigned W = 10;
  localparam int unsigned H = 20;
  localparam int unsigned N = W * H;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0;
  logic [5:0] ram_q;
  logic [7:0] ram_addr;
  logic       ram_wren;
  logic [5:0] ram_data;
  logic       busy;
  logic       complete;
  logic [2:0] lines_cleared;

  always #5 clk = ~clk;

  line_clear #(.BOARD_W(W), .BOARD_H(H)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .go           (go),
    .ram_q        (ram_q),
    .ram_addr     (ram_addr),
    .ram_wren     (ram_wren),
    .ram_data     (ram_data),
    .busy         (busy),
    .complete     (complete),
    .lines_cleared(lines_cleared)
  );

  logic [5:0] mem        [256];
  logic [5:0] init_board [256];
  logic [5:0] exp_board  [256];
  logic       load = 1'b0;

  // Synchronous RAM: one cycle read latency, bulk load from init_board.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_board[i];
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
    end
    ram_q <= mem[ram_addr];
  end

  int tests = 0;
  int fails = 0;

  int done_cyc, shift_wr, clear_wr, completes, bad_data;
  int exp_lines, exp_shift, n_full;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: drop full rows, keep the rest in order, pad with empty rows on top.
  // Row clears work bottom-up, so a full row sits (r + full rows below it) when it is removed.
  task automatic model();
    int  dst;
    bit  is_full;
    for (int i = 0; i < 256; i++) exp_board[i] = 6'd0;
    dst = H - 1;
    n_full = 0;
    exp_shift = 0;
    for (int r = H - 1; r >= 0; r--) begin
      is_full = 1'b1;
      for (int c = 0; c < W; c++) if (init_board[r * W + c] == 6'd0) is_full = 1'b0;
      if (is_full) begin
        exp_shift += (r + n_full) * W;
        n_full++;
      end else begin
        for (int c = 0; c < W; c++) exp_board[dst * W + c] = init_board[r * W + c];
        dst--;
      end
    end
    exp_lines = (n_full > 7) ? 7 : n_full;
  endtask

  task automatic clear_init();
    for (int i = 0; i < 256; i++) init_board[i] = 6'd0;
  endtask

  task automatic fill_row(input int r, input logic [5:0] v);
    for (int c = 0; c < W; c++) init_board[r * W + c] = v;
  endtask

  task automatic cmp_board(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_board[i]) bad++;
    check(tag, bad, 0);
  endtask

  // Load init_board, pulse go for `hold` cycles, and watch the bus until 6 cycles past complete.
  task automatic run_op(input int hold);
    int n;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    go = 1'b1;
    n = 0;
    done_cyc = -1;
    shift_wr = 0;
    clear_wr = 0;
    completes = 0;
    bad_data = 0;
    while (n < 20000) begin
      @(negedge clk);
      n++;
      if (n >= hold) go = 1'b0;
      if (ram_wren) begin
        if (ram_addr < 8'(W)) clear_wr++;
        else shift_wr++;
      end else if (ram_data != 6'd0) begin
        bad_data++;
      end
      if (complete) begin
        completes++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (done_cyc >= 0 && n >= done_cyc + 6) break;
    end
    go = 1'b0;
  endtask

  initial begin
    int n;
    int writes;
    bit hit;

    clear_init();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_complete", complete, 0);
    check("reset_wren", ram_wren, 0);
    check("reset_lines", lines_cleared, 0);
    check("reset_addr", ram_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Empty board.
    clear_init();
    model();
    run_op(1);
    check("empty_done_cycle", done_cyc, 41);
    check("empty_lines", lines_cleared, 0);
    check("empty_writes", shift_wr + clear_wr, 0);
    check("empty_completes", completes, 1);
    check("empty_idle_busy", busy, 0);
    check("empty_idle_addr", ram_addr, 0);
    cmp_board("empty_board");

    // Bottom row full.
    clear_init();
    fill_row(19, 6'h05);
    model();
    run_op(1);
    check("row19_done_cycle", done_cyc, 20 + 380 + 10 + 40 + 1);
    check("row19_lines", lines_cleared, 1);
    check("row19_shift_wr", shift_wr, 190);
    check("row19_clear_wr", clear_wr, 10);
    check("row19_bad_data", bad_data, 0);
    cmp_board("row19_board");
    repeat (5) @(negedge clk);
    check("row19_lines_hold", lines_cleared, 1);

    // Two full rows with a lone cell above them.
    clear_init();
    fill_row(18, 6'h11);
    fill_row(19, 6'h3F);
    init_board[17 * W + 3] = 6'h2A;
    model();
    run_op(1);
    check("two_lines", lines_cleared, 2);
    check("two_cell_19_3", mem[19 * W + 3], 6'h2A);
    check("two_completes", completes, 1);
    cmp_board("two_board");

    // Whole board full: count saturates.
    clear_init();
    for (int r = 0; r < H; r++) fill_row(r, 6'(r + 1));
    model();
    run_op(1);
    check("all_lines_sat", lines_cleared, 7);
    check("all_completes", completes, 1);
    check("all_shift_wr", shift_wr, exp_shift);
    check("all_clear_wr", clear_wr, 20 * W);
    cmp_board("all_board");

    // go held for 3 cycles: ignored once busy; lines_cleared restarts from 0.
    clear_init();
    model();
    run_op(3);
    check("hold3_completes", completes, 1);
    check("hold3_done_cycle", done_cyc, 41);
    check("hold3_lines", lines_cleared, 0);
    check("hold3_no_restart", busy, 0);

    // go held across DONE restarts on the IDLE cycle.
    clear_init();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    go = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (complete) hit = 1'b1;
    end
    check("reissue_first_complete", hit, 1);
    @(negedge clk);
    check("reissue_idle", busy, 0);
    @(negedge clk);
    check("reissue_restart", busy, 1);
    go = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (complete) hit = 1'b1;
    end
    check("reissue_second_complete", hit, 1);
    repeat (3) @(negedge clk);

    // Reset asserted during a shift write.
    clear_init();
    fill_row(19, 6'h07);
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (ram_wren && ram_addr >= 8'(W)) hit = 1'b1;
    end
    check("rst_reached_shift_wr", hit, 1);
    reset_n = 1'b0;
    #1;
    check("rst_wren", ram_wren, 0);
    check("rst_busy", busy, 0);
    check("rst_complete", complete, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_addr", ram_addr, 0);
    writes = 0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (ram_wren) writes++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ram_wren) writes++;
      if (busy) n++;
    end
    check("rst_no_writes", writes, 0);
    check("rst_stays_idle", n, 0);
    model();
    run_op(1);
    check("rst_fresh_done_cycle", done_cyc, 451);
    check("rst_fresh_lines", lines_cleared, 1);
    cmp_board("rst_fresh_board");

    // Random boards.
    for (int k = 0; k < 8; k++) begin
      clear_init();
      for (int r = 0; r < H; r++) begin
        if ($urandom_range(0, 2) == 0) begin
          for (int c = 0; c < W; c++) init_board[r * W + c] = 6'($urandom_range(1, 63));
        end else if ($urandom_range(0, 3) != 0) begin
          for (int c = 0; c < W; c++)
            init_board[r * W + c] = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
          init_board[r * W + int'($urandom_range(0, W - 1))] = 6'd0;
        end
      end
      model();
      run_op(1);
      check($sformatf("rand%0d_lines", k), lines_cleared, exp_lines);
      check($sformatf("rand%0d_shift_wr", k), shift_wr, exp_shift);
      check($sformatf("rand%0d_clear_wr", k), clear_wr, n_full * W);
      check($sformatf("rand%0d_completes", k), completes, 1);
      check($sformatf("rand%0d_bad_data", k), bad_data, 0);
      cmp_board($sformatf("rand%0d_board", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
